cpu_step_controller: RTL and testbench
======================================

Name: cpu_step_controller

Overview:
Sequences execution of the MIPS core by generating a single-clock-domain instruction enable (cpu_en) in place of a button-driven core clock.
Supports four modes: halted, single-step, free-run at a divided rate, and burst of N back-to-back instructions.
Also provides a PC breakpoint that halts the core before the matching instruction executes.
Sits between the board inputs (debounced button, switches) and the mips core's clock-enable, and also feeds the debug LED display.

Parameters:
RATE_DIV, 50000, clock cycles between enables in RUN mode (>=2)
CNT_W, 16, width of burst length and remaining-burst counter

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
step_req  input  1  debounced step button level; rising edge detected internally
run_req  input  1  run switch level; high = run
burst_req  input  1  one-cycle pulse; starts a burst
burst_len  input  CNT_W  number of instructions in a burst, sampled with burst_req
bp_enable  input  1  breakpoint enable
bp_addr  input  32  breakpoint PC
pc  input  32  current core PC, i.e. address of the instruction that executes on the next cpu_en
cpu_en  output  1  core clock-enable; one instruction retires per clock with cpu_en=1
mode  output  2  0=HALTED, 1=STEP, 2=RUN, 3=BURST
bp_hit  output  1  sticky; set when a breakpoint stopped execution
cycle_count  output  32  count of clocks with cpu_en=1

Behaviour:
- Reset (asynchronous, reset=0):
  - mode=HALTED, bp_hit=0, cycle_count=0.
  - Divider=0, remaining=0, step edge register=0, skip=0.
  - cpu_en=0 immediately, because it is derived from registered state.
- Step edge: step_edge = step_req & ~step_q, where step_q is step_req registered.
- break_now = bp_enable & (pc==bp_addr) & ~skip. This is combinational on the current pc.
- HALTED, priority order for the next state:
  - burst_req with burst_len!=0 -> BURST, remaining<=burst_len.
  - Else step_edge -> STEP.
  - Else run_req -> RUN, divider<=0.
  - burst_req with burst_len==0 is ignored.
  - Any exit from HALTED sets skip=1 and clears bp_hit.
- STEP:
  - cpu_en=1 for exactly this one cycle; the breakpoint is never checked.
  - Next state is HALTED unconditionally; skip<=0.
- RUN:
  - Divider counts 0..RATE_DIV-1 and wraps.
  - tick = (divider==RATE_DIV-1).
  - cpu_en = tick & run_req & ~break_now.
  - First enable occurs RATE_DIV cycles after entering RUN.
  - run_req=0 -> HALTED next cycle, no enable that cycle; deassertion wins over a coincident tick.
  - tick & break_now -> HALTED, bp_hit<=1, no enable.
- BURST:
  - cpu_en = ~break_now every cycle; remaining decrements on each enable.
  - Enable with remaining==1 -> HALTED next cycle; exactly burst_len enables are issued.
  - break_now -> HALTED, bp_hit<=1, remaining<=0.
  - burst_req, step_edge and run_req are ignored while in BURST.
- skip clears on the first cycle with cpu_en=1. Resuming from a breakpoint therefore executes the matching instruction once before breakpoints re-arm.
- In STEP and RUN, step_edge and burst_req are ignored (not queued).
- cycle_count increments on every clock with cpu_en=1 and wraps modulo 2^32.
- mode reflects the registered state. bp_hit holds until the next exit from HALTED.

Test Plan:
- Reset released, all inputs 0 for 10 cycles -> mode=0, cpu_en=0, cycle_count=0.
- step_req held high for 5 cycles -> exactly one cpu_en pulse (1 cycle), mode returns to 0, cycle_count=1.
- RATE_DIV=4, run_req=1 for 17 cycles, then 0 -> cpu_en pulses at cycles 4, 8, 12, 16 after entry; 4 pulses total, then HALTED.
- burst_req with burst_len=5 -> 5 consecutive cpu_en cycles, then mode=0, cycle_count=+5. Repeat with burst_len=0 -> no pulses, mode stays 0.
- bp_enable=1, bp_addr=0x10; burst of 8 with a core model incrementing pc by 4 from 0 -> 4 enables (pc 0..0xC), stop with bp_hit=1 at pc=0x10. A new burst of 2 -> pc advances to 0x18, bp_hit=0.
- Assert reset mid-BURST (remaining=3) -> cpu_en=0 and mode=0 in the same cycle, cycle_count=0. After release, no pulses until a new request.

Source files
------------

// File: rtl/cpu_step_controller.sv
// Instruction-enable sequencer for the MIPS core: halt, single-step, divided free-run
// and N-instruction burst, with a PC breakpoint that stops before the matching instruction.
//
// state  | meaning
// -------+-------------------------------------------------------------
// HALTED | no enables; waits for burst, step edge or run request
// STEP   | one enable this cycle, then back to HALTED
// RUN    | one enable every RATE_DIV cycles while run_req is held
// BURST  | one enable per cycle until remaining runs out or a breakpoint
module cpu_step_controller #(
  parameter int RATE_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             step_req,
  input  logic             run_req,
  input  logic             burst_req,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             bp_enable,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc,
  output logic             cpu_en,
  output logic [1:0]       mode,
  output logic             bp_hit,
  output logic [31:0]      cycle_count
);

  localparam int DIV_W = (RATE_DIV > 2) ? $clog2(RATE_DIV) : 1;

  localparam logic [1:0] HALTED = 2'd0;
  localparam logic [1:0] STEP   = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;
  localparam logic [1:0] BURST  = 2'd3;

  logic             step_q;
  logic             skip;
  logic [DIV_W-1:0] divider;
  logic [CNT_W-1:0] remaining;
  logic             step_edge;
  logic             break_now;
  logic             tick;

  always_comb begin
    step_edge = step_req & ~step_q;
    // skip lets the instruction we stopped on execute once after resuming
    break_now = bp_enable & (pc == bp_addr) & ~skip;
    tick      = (divider == DIV_W'(RATE_DIV - 1));
    cpu_en    = 1'b0;
    case (mode)
      STEP:    cpu_en = 1'b1;
      RUN:     cpu_en = tick & run_req & ~break_now;
      BURST:   cpu_en = ~break_now;
      default: cpu_en = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode        <= HALTED;
      bp_hit      <= 1'b0;
      cycle_count <= 32'd0;
      divider     <= '0;
      remaining   <= '0;
      step_q      <= 1'b0;
      skip        <= 1'b0;
    end else begin
      step_q <= step_req;
      if (cpu_en) begin
        cycle_count <= cycle_count + 32'd1;
        skip        <= 1'b0;
      end
      case (mode)
        HALTED: begin
          if (burst_req && (burst_len != '0)) begin
            mode      <= BURST;
            remaining <= burst_len;
            skip      <= 1'b1;
            bp_hit    <= 1'b0;
          end else if (step_edge) begin
            mode   <= STEP;
            skip   <= 1'b1;
            bp_hit <= 1'b0;
          end else if (run_req) begin
            mode    <= RUN;
            divider <= '0;
            skip    <= 1'b1;
            bp_hit  <= 1'b0;
          end
        end
        STEP: begin
          mode <= HALTED;
          skip <= 1'b0;
        end
        RUN: begin
          divider <= tick ? '0 : divider + DIV_W'(1);
          if (!run_req) begin
            mode <= HALTED;
          end else if (tick && break_now) begin
            mode   <= HALTED;
            bp_hit <= 1'b1;
          end
        end
        BURST: begin
          if (break_now) begin
            mode      <= HALTED;
            bp_hit    <= 1'b1;
            remaining <= '0;
          end else begin
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) mode <= HALTED;
          end
        end
        default: mode <= HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed bench for cpu_step_controller with a small core model advancing pc by 4 per enable.
module tb_cpu_step_controller;

  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             step_req = 1'b0;
  logic             run_req = 1'b0;
  logic             burst_req = 1'b0;
  logic [CNT_W-1:0] burst_len = '0;
  logic             bp_enable = 1'b0;
  logic [31:0]      bp_addr = 32'd0;
  logic [31:0]      pc = 32'd0;
  logic             pc_clr = 1'b0;
  logic             cpu_en;
  logic [1:0]       mode;
  logic             bp_hit;
  logic [31:0]      cycle_count;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses;

  cpu_step_controller #(.RATE_DIV(4), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .step_req(step_req), .run_req(run_req),
    .burst_req(burst_req), .burst_len(burst_len), .bp_enable(bp_enable),
    .bp_addr(bp_addr), .pc(pc), .cpu_en(cpu_en), .mode(mode),
    .bp_hit(bp_hit), .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (pc_clr) pc <= 32'd0;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic count_pulses(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (cpu_en) cnt++;
    end
  endtask

  initial begin
    #12 reset = 1'b1;
    count_pulses(10, pulses);
    chk("reset_pulses", pulses, 0);
    chk("reset_mode", mode, 0);
    chk("reset_cpu_en", cpu_en, 0);
    chk("reset_count", cycle_count, 0);

    // step held for 5 cycles: one enable only
    step_req = 1'b1;
    count_pulses(5, pulses);
    step_req = 1'b0;
    count_pulses(3, pulses);
    chk("step_mode", mode, 0);
    chk("step_count", cycle_count, 1);

    // run: enables on cycles 4, 8, 12, 16 after entry
    @(negedge clock);
    run_req = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clock);
      if (cpu_en) pulses++;
      if ((k % 4) == 0) chk($sformatf("run_en_c%0d", k), cpu_en, 1);
      else if (k == 1 || k == 3 || k == 17) chk($sformatf("run_en_c%0d", k), cpu_en, 0);
    end
    run_req = 1'b0;
    @(negedge clock);
    chk("run_pulses", pulses, 4);
    chk("run_mode_after", mode, 0);
    chk("run_count", cycle_count, 5);

    // run dropped on the tick cycle: no enable
    run_req = 1'b1;
    count_pulses(3, pulses);
    chk("run2_early", pulses, 0);
    @(negedge clock);
    run_req = 1'b0;
    #1 chk("run2_drop_tick", cpu_en, 0);
    @(negedge clock);
    chk("run2_mode", mode, 0);
    chk("run2_count", cycle_count, 5);

    // burst of 5
    burst_len = 16'd5;
    burst_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      burst_req = 1'b0;
      chk($sformatf("burst5_en%0d", k), cpu_en, 1);
      chk($sformatf("burst5_mode%0d", k), mode, 3);
    end
    @(negedge clock);
    chk("burst5_done_en", cpu_en, 0);
    chk("burst5_done_mode", mode, 0);
    chk("burst5_count", cycle_count, 10);

    // burst of 0 is ignored
    burst_len = 16'd0;
    burst_req = 1'b1;
    @(negedge clock);
    burst_req = 1'b0;
    chk("burst0_mode", mode, 0);
    count_pulses(4, pulses);
    chk("burst0_pulses", pulses, 0);
    chk("burst0_count", cycle_count, 10);

    // breakpoint at 0x10
    pc_clr = 1'b1;
    @(negedge clock);
    pc_clr = 1'b0;
    chk("pc_cleared", pc, 0);
    bp_enable = 1'b1;
    bp_addr = 32'h10;
    burst_len = 16'd8;
    burst_req = 1'b1;
    @(negedge clock);
    burst_req = 1'b0;
    pulses = cpu_en ? 1 : 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      if (cpu_en) pulses++;
    end
    chk("bp_pulses", pulses, 4);
    chk("bp_pc", pc, 32'h10);
    chk("bp_hit_set", bp_hit, 1);
    chk("bp_mode", mode, 0);
    chk("bp_count", cycle_count, 14);

    burst_len = 16'd2;
    burst_req = 1'b1;
    @(negedge clock);
    burst_req = 1'b0;
    chk("resume_first_en", cpu_en, 1);
    chk("resume_bp_hit_clr", bp_hit, 0);
    pulses = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (cpu_en) pulses++;
    end
    chk("resume_pulses", pulses, 2);
    chk("resume_pc", pc, 32'h18);
    chk("resume_bp_hit", bp_hit, 0);
    chk("resume_mode", mode, 0);

    // async reset mid-burst with remaining=3
    bp_enable = 1'b0;
    burst_len = 16'd5;
    burst_req = 1'b1;
    @(negedge clock);
    burst_req = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("midburst_en", cpu_en, 1);
    reset = 1'b0;
    #1;
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_mode", mode, 0);
    chk("rst_count", cycle_count, 0);
    chk("rst_bp_hit", bp_hit, 0);
    @(negedge clock);
    reset = 1'b1;
    count_pulses(10, pulses);
    chk("post_rst_pulses", pulses, 0);
    chk("post_rst_mode", mode, 0);
    chk("post_rst_count", cycle_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
